mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-client arbiter that shares the single line-granular main_mem port between the instruction cache (client A) and the data cache (client B).
- Each client uses the same rd_req/wr_req/addr/line/gnt protocol that main_mem exposes. The arbiter therefore sits transparently between the caches and main_mem.
- Round-robin arbitration, with a write-then-fill lock so that a cache's SWAP_OUT→SWAP_IN pair is never split by the other client.

Parameters:
- LINE_ADDR_LEN, 3, words per line = 2^LINE_ADDR_LEN
- ADDR_LEN, 9, main-memory line address width (tag + set)
- CNT_LEN, 16, width of the per-client grant counters

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- a_addr  in  ADDR_LEN  client A line address
- a_rd_req  in  1  client A line read request, held until a_gnt
- a_wr_req  in  1  client A line write request, held until a_gnt
- a_wr_line  in  32 x LINE_SIZE (unpacked)  client A write line
- a_rd_line  out  32 x LINE_SIZE  read line returned to A
- a_gnt  out  1  one-cycle completion pulse to A
- b_addr, b_rd_req, b_wr_req, b_wr_line, b_rd_line, b_gnt: same as A, for client B
- mem_addr  out  ADDR_LEN  to main_mem
- mem_rd_req  out  1  to main_mem
- mem_wr_req  out  1  to main_mem
- mem_wr_line  out  32 x LINE_SIZE  to main_mem
- mem_rd_line  in  32 x LINE_SIZE  from main_mem
- mem_gnt  in  1  main_mem completion pulse
- busy  out  1  high while a transaction is in flight
- a_grant_cnt  out  CNT_LEN  completed A transactions, saturating
- b_grant_cnt  out  CNT_LEN  completed B transactions, saturating

Behaviour:
- States:
  - IDLE
  - BUSY: owner, op (rd/wr), addr and wr_line are registered at entry
  - DONE: one-cycle gap after mem_gnt
- Reset (rst=0, asynchronous, any state):
  - state ← IDLE; rr_ptr ← A; lock ← none.
  - mem_rd_req = mem_wr_req = 0, mem_addr = 0, mem_wr_line = 0.
  - a_gnt = b_gnt = 0, busy = 0, both counters = 0, a_rd_line = b_rd_line = 0.
  - Reset mid-transaction drops the mem request immediately. A mem_gnt arriving after reset is ignored.
- IDLE, client selection:
  - A client is requesting when rd_req|wr_req.
  - Only one requesting → that client.
  - Both requesting → lock holder if lock is set, otherwise the client at rr_ptr.
  - On selection, go to BUSY next edge and latch: owner, op (wr if wr_req else rd; wr wins if both asserted), addr, wr_line.
- BUSY:
  - mem_rd_req/mem_wr_req come from registered op; mem_addr and mem_wr_line come from the registers.
  - A client changing its inputs mid-transaction has no effect.
  - On mem_gnt=1, combinationally in the same cycle: owner's gnt=1, and owner's rd_line = mem_rd_line (rd op).
  - Next edge → DONE. The owner's counter increments (held at 2^CNT_LEN-1).
  - rr_ptr ← the other client.
  - lock ← owner if op=wr, else none.
- rd_line hold: a_rd_line/b_rd_line are registered copies, updated only on that client's read gnt and held afterwards.
- DONE:
  - mem requests are 0, so main_mem sees requests deasserted for at least one cycle. Go to IDLE next edge.
  - lock is cleared on the first IDLE selection that uses it, or if the lock holder is not requesting in that IDLE cycle.
- Latency:
  - Request seen in IDLE at cycle t → mem request from t+1.
  - mem_gnt at g → client gnt at g → next mem request no earlier than g+3.
- busy = (state != IDLE).
- A non-owner never receives gnt. A gnt is never issued without mem_gnt.
- mem_gnt while in IDLE or DONE is ignored.

Test Plan:
- Reset with rst=0 mid-BUSY (A read outstanding) → mem_rd_req falls asynchronously, all outputs 0; after release, state is IDLE and counters are 0.
- Only A reads addr 0x05, mem_gnt after 50 cycles with line {0..7} → mem_addr=0x05 from t+1, a_gnt pulse in the same cycle as mem_gnt, a_rd_line={0..7}, a_grant_cnt=1, b_gnt never asserted.
- A and B both read (0x10, 0x20) simultaneously from reset → A served first, then B; order A,B,A,B over 4 back-to-back rounds; counters 2/2.
- B writes 0x33 then reads 0x44 (dirty swap) while A continuously requests → B write, B read, then A; A is not granted between B's two transactions.
- A holds a_rd_req and a_wr_req together with a_addr=0x7 → mem_wr_req=1, mem_rd_req=0.
- Counter saturation with CNT_LEN=2: 5 A grants → a_grant_cnt stays 3.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a line-granular main memory.
// A client's line write followed by its line fill (dirty swap) is kept
// together: after a write the same client wins the next contended IDLE slot.
module mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int CNT_LEN       = 16,
  localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] a_addr,
  input  logic                a_rd_req,
  input  logic                a_wr_req,
  input  logic [31:0]         a_wr_line [LINE_SIZE],
  output logic [31:0]         a_rd_line [LINE_SIZE],
  output logic                a_gnt,
  input  logic [ADDR_LEN-1:0] b_addr,
  input  logic                b_rd_req,
  input  logic                b_wr_req,
  input  logic [31:0]         b_wr_line [LINE_SIZE],
  output logic [31:0]         b_rd_line [LINE_SIZE],
  output logic                b_gnt,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [31:0]         mem_wr_line [LINE_SIZE],
  input  logic [31:0]         mem_rd_line [LINE_SIZE],
  input  logic                mem_gnt,
  output logic                busy,
  output logic [CNT_LEN-1:0]  a_grant_cnt,
  output logic [CNT_LEN-1:0]  b_grant_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q;
  logic                owner_b_q;   // 0 = A, 1 = B
  logic                op_wr_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [31:0]         wline_q [LINE_SIZE];
  logic                rr_b_q;      // round-robin pointer, 1 = B next
  logic                lock_vld_q;
  logic                lock_b_q;
  logic [CNT_LEN-1:0]  a_cnt_q, b_cnt_q;
  logic [31:0]         a_rdl_q [LINE_SIZE];
  logic [31:0]         b_rdl_q [LINE_SIZE];

  logic a_req, b_req, sel_vld, sel_b;
  logic in_busy, fin, rd_fin;

  assign a_req   = a_rd_req | a_wr_req;
  assign b_req   = b_rd_req | b_wr_req;
  assign sel_vld = a_req | b_req;
  assign in_busy = (state_q == S_BUSY);
  // mem_gnt only counts while a transaction is outstanding
  assign fin     = in_busy & mem_gnt;
  assign rd_fin  = fin & ~op_wr_q;

  // Client pick: the lone requester, else lock holder, else round-robin pointer
  always_comb begin
    sel_b = b_req;
    if (a_req && b_req) sel_b = lock_vld_q ? lock_b_q : rr_b_q;
  end

  // Arbitration FSM with transaction registers, counters and read-line copies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_b_q  <= 1'b0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      rr_b_q     <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_b_q   <= 1'b0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
        wline_q[i] <= '0;
        a_rdl_q[i] <= '0;
        b_rdl_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Any IDLE cycle either consumes the lock or finds its holder idle
          lock_vld_q <= 1'b0;
          if (sel_vld) begin
            state_q   <= S_BUSY;
            owner_b_q <= sel_b;
            op_wr_q   <= sel_b ? b_wr_req : a_wr_req;
            addr_q    <= sel_b ? b_addr : a_addr;
            for (int i = 0; i < LINE_SIZE; i++)
              wline_q[i] <= sel_b ? b_wr_line[i] : a_wr_line[i];
          end
        end
        S_BUSY: begin
          if (mem_gnt) begin
            state_q    <= S_DONE;
            rr_b_q     <= ~owner_b_q;
            lock_vld_q <= op_wr_q;
            lock_b_q   <= owner_b_q;
            if (!owner_b_q) begin
              if (a_cnt_q != {CNT_LEN{1'b1}}) a_cnt_q <= a_cnt_q + CNT_LEN'(1);
            end else begin
              if (b_cnt_q != {CNT_LEN{1'b1}}) b_cnt_q <= b_cnt_q + CNT_LEN'(1);
            end
            if (!op_wr_q) begin
              for (int i = 0; i < LINE_SIZE; i++) begin
                if (!owner_b_q) a_rdl_q[i] <= mem_rd_line[i];
                else            b_rdl_q[i] <= mem_rd_line[i];
              end
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_req  = in_busy & ~op_wr_q;
  assign mem_wr_req  = in_busy &  op_wr_q;
  assign mem_addr    = addr_q;
  assign mem_wr_line = wline_q;
  assign a_gnt       = fin & ~owner_b_q;
  assign b_gnt       = fin &  owner_b_q;
  assign busy        = (state_q != S_IDLE);
  assign a_grant_cnt = a_cnt_q;
  assign b_grant_cnt = b_cnt_q;

  // Returned lines pass straight through on the grant cycle, then hold
  always_comb begin
    for (int i = 0; i < LINE_SIZE; i++) begin
      a_rd_line[i] = (rd_fin && !owner_b_q) ? mem_rd_line[i] : a_rdl_q[i];
      b_rd_line[i] = (rd_fin &&  owner_b_q) ? mem_rd_line[i] : b_rdl_q[i];
    end
  end

endmodule
